// File: rtl/id_pkg.sv
// Shared decode-stage definitions: register address width, register count, zero register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage : id_pkg

// File: rtl/popcount_reg.sv
// Registered population count of a bit vector.
// Latency: one cycle from vec to cnt.
// Backpressure: none; the count is recomputed every cycle.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (cnt -> 0)
//   vec        : vector to count
//   cnt        : number of set bits in vec, registered
module popcount_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum = sum + CNT_W'(vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= sum;
        end
    end

endmodule : popcount_reg

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight register writes and stalls ID on RAW/WAW hazards.
// Latency: stall/issue are combinational from registered state; pending updates at the next edge.
// Backpressure: stall holds ID until writeback retires the hazard register or a flush clears all.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   idValid, useRs, useRt, rs, rt   : decoded instruction and its source operands
//   regWrite, writeAddress          : destination of the decoded instruction
//   wbValid, wbAddress              : writeback retiring a register
//   flush                           : drop every in-flight write
//   stall, issue                    : ID hold / instruction leaves ID
//   pendingCount                    : registered count of pending registers
//   stallCycles                     : saturating stalled-cycle counter
//   wbError, deadlock               : sticky error flags
//
// Build option HZ_WB_BYPASS_EN: a same-cycle writeback masks the hazard on its register
// (register file writes before it reads), removing the one-cycle bubble after writeback.
module id_hazard_scoreboard
    import id_pkg::*;
#(
    parameter int NUM_REGS    = NUM_ARCH_REGS,
    parameter int ADDR_W      = REG_ADDR_W,
    parameter int STALL_CNT_W = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   idValid,
    input  logic                   useRs,
    input  logic                   useRt,
    input  logic [ADDR_W-1:0]      rs,
    input  logic [ADDR_W-1:0]      rt,
    input  logic                   regWrite,
    input  logic [ADDR_W-1:0]      writeAddress,
    input  logic                   wbValid,
    input  logic [ADDR_W-1:0]      wbAddress,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue,
    output logic [ADDR_W:0]        pendingCount,
    output logic [STALL_CNT_W-1:0] stallCycles,
    output logic                   wbError,
    output logic                   deadlock
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] hz_pending;   // pending as seen by the hazard check
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [RUN_W-1:0]    run_cnt;

    logic wb_live;
    logic raw_rs;
    logic raw_rt;
    logic waw;
    logic set_en;

    assign wb_live = wbValid && (wbAddress != ZERO_ADDR);
    assign clr_vec = wb_live ? (NUM_REGS'(1) << wbAddress) : '0;

`ifdef HZ_WB_BYPASS_EN
    // Retiring register is already visible in the register file this cycle.
    assign hz_pending = pending & ~clr_vec;
`else
    assign hz_pending = pending;
`endif

    assign raw_rs = useRs && (rs != ZERO_ADDR) && hz_pending[rs];
    assign raw_rt = useRt && (rt != ZERO_ADDR) && hz_pending[rt];
    assign waw    = regWrite && (writeAddress != ZERO_ADDR) && hz_pending[writeAddress];

    assign stall  = idValid && (raw_rs || raw_rt || waw) && !flush;
    assign issue  = idValid && !stall && !flush;

    assign set_en  = issue && regWrite && (writeAddress != ZERO_ADDR);
    assign set_vec = set_en ? (NUM_REGS'(1) << writeAddress) : '0;

    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            // Clear first so a same-register set in the same cycle wins.
            pending_nxt = (pending & ~clr_vec) | set_vec;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            stallCycles <= '0;
            run_cnt     <= '0;
            wbError     <= 1'b0;
            deadlock    <= 1'b0;
        end else begin
            pending <= pending_nxt;

            if (!flush && wb_live && !pending[wbAddress]) begin
                wbError <= 1'b1;
            end

            if (stall && (stallCycles != '1)) begin
                stallCycles <= stallCycles + 1'b1;
            end

            if (stall) begin
                if (run_cnt != RUN_W'(STALL_LIMIT)) begin
                    run_cnt <= run_cnt + 1'b1;
                end
                // This edge completes the STALL_LIMIT-th consecutive stalled cycle.
                if (run_cnt == RUN_W'(STALL_LIMIT - 1)) begin
                    deadlock <= 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    popcount_reg #(
        .WIDTH (NUM_REGS),
        .CNT_W (ADDR_W + 1)
    ) u_pending_cnt (
        .clk   (clk),
        .reset (reset),
        .vec   (pending),
        .cnt   (pendingCount)
    );

endmodule : id_hazard_scoreboard

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        idValid, useRs, useRt, regWrite, wbValid, flush;
    logic [4:0]  rs, rt, writeAddress, wbAddress;
    logic        stall, issue, wbError, deadlock;
    logic [5:0]  pendingCount;
    logic [15:0] stallCycles;

    int checks   = 0;
    int failures = 0;

`ifdef HZ_WB_BYPASS_EN
    localparam logic WB_CYCLE_STALL = 1'b0;
    localparam int   RAW_STALLS     = 3;
`else
    localparam logic WB_CYCLE_STALL = 1'b1;
    localparam int   RAW_STALLS     = 4;
`endif

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .idValid      (idValid),
        .useRs        (useRs),
        .useRt        (useRt),
        .rs           (rs),
        .rt           (rt),
        .regWrite     (regWrite),
        .writeAddress (writeAddress),
        .wbValid      (wbValid),
        .wbAddress    (wbAddress),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .pendingCount (pendingCount),
        .stallCycles  (stallCycles),
        .wbError      (wbError),
        .deadlock     (deadlock)
    );

    task automatic idle();
        idValid = 0; useRs = 0; useRt = 0; regWrite = 0; wbValid = 0; flush = 0;
        rs = 0; rt = 0; writeAddress = 0; wbAddress = 0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input logic [4:0] a);
        idle();
        idValid = 1; regWrite = 1; writeAddress = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (issue !== 1'b0) begin failures++; $display("FAIL reset_issue: got %b want 0", issue); end
        checks++; if (pendingCount !== 6'd0) begin failures++; $display("FAIL reset_pcount: got %0d want 0", pendingCount); end
        checks++; if (stallCycles !== 16'd0) begin failures++; $display("FAIL reset_scycles: got %0d want 0", stallCycles); end
        checks++; if (wbError !== 1'b0) begin failures++; $display("FAIL reset_wberr: got %b want 0", wbError); end
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL reset_deadlock: got %b want 0", deadlock); end
    endtask

    task automatic test_issue_r5();
        idValid = 1; regWrite = 1; writeAddress = 5;
        #1;
        checks++; if (issue !== 1'b1) begin failures++; $display("FAIL r5_issue: got %b want 1", issue); end
        tick();
        idle();
        #1;
        // pending[5] is set now; the registered count lags one more cycle.
        checks++; if (pendingCount !== 6'd0) begin failures++; $display("FAIL r5_pcount_lag: got %0d want 0", pendingCount); end
        tick();
        checks++; if (pendingCount !== 6'd1) begin failures++; $display("FAIL r5_pcount: got %0d want 1", pendingCount); end
    endtask

    task automatic test_raw_wb();
        idValid = 1; useRs = 1; rs = 5;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1 || issue !== 1'b0) begin failures++; $display("FAIL raw_hold%0d: got stall=%b issue=%b want stall=1 issue=0", i, stall, issue); end
            tick();
        end
        wbValid = 1; wbAddress = 5;
        #1;
        checks++; if (stall !== WB_CYCLE_STALL) begin failures++; $display("FAIL raw_wb_cycle: got %b want %b", stall, WB_CYCLE_STALL); end
        tick();
        wbValid = 0; wbAddress = 0;
        #1;
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin failures++; $display("FAIL raw_release: got stall=%b issue=%b want stall=0 issue=1", stall, issue); end
        idle();
        tick(); tick();
        checks++; if (stallCycles !== 16'(RAW_STALLS)) begin failures++; $display("FAIL raw_scycles: got %0d want %0d", stallCycles, RAW_STALLS); end
        checks++; if (pendingCount !== 6'd0) begin failures++; $display("FAIL raw_pcount: got %0d want 0", pendingCount); end
        checks++; if (wbError !== 1'b0) begin failures++; $display("FAIL raw_wberr: got %b want 0", wbError); end
    endtask

    task automatic test_r0();
        issue_write(5'd0);
        idValid = 1; useRs = 1; rs = 0; useRt = 1; rt = 0; regWrite = 1; writeAddress = 0;
        #1;
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin failures++; $display("FAIL r0_read: got stall=%b issue=%b want stall=0 issue=1", stall, issue); end
        tick();
        idle();
        tick();
        checks++; if (pendingCount !== 6'd0) begin failures++; $display("FAIL r0_pcount: got %0d want 0", pendingCount); end
    endtask

    task automatic test_waw();
        issue_write(5'd6);
        idValid = 1; regWrite = 1; writeAddress = 6;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall: got %b want 1", stall); end
        tick();
        wbValid = 1; wbAddress = 6;
        tick();
        wbValid = 0; wbAddress = 0;
        #1;
        checks++; if (issue !== 1'b1) begin failures++; $display("FAIL waw_issue: got %b want 1", issue); end
        tick();
        idle();
        tick();
        // r6 was retired then re-written by the WAW instruction.
        checks++; if (pendingCount !== 6'd1) begin failures++; $display("FAIL waw_pcount: got %0d want 1", pendingCount); end
        wbValid = 1; wbAddress = 6;
        tick();
        idle();
    endtask

    task automatic test_flush();
        issue_write(5'd3);
        issue_write(5'd7);
        tick();
        checks++; if (pendingCount !== 6'd2) begin failures++; $display("FAIL flush_pre_pcount: got %0d want 2", pendingCount); end
        idValid = 1; useRt = 1; rt = 7;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_pre_rt: got %b want 1", stall); end
        idle();
        idValid = 1; regWrite = 1; writeAddress = 9; flush = 1; wbValid = 1; wbAddress = 20;
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL flush_issue: got issue=%b stall=%b want 0 0", issue, stall); end
        tick();
        idle();
        idValid = 1; useRs = 1; rs = 3; useRt = 1; rt = 7;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_r3r7: got %b want 0", stall); end
        useRs = 0; useRt = 0; regWrite = 1; writeAddress = 9;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_r9: got %b want 0", stall); end
        idle();
        tick();
        checks++; if (pendingCount !== 6'd0) begin failures++; $display("FAIL flush_pcount: got %0d want 0", pendingCount); end
        checks++; if (wbError !== 1'b0) begin failures++; $display("FAIL flush_wberr: got %b want 0", wbError); end
    endtask

    task automatic test_wb_error();
        wbValid = 1; wbAddress = 12;
        tick();
        idle();
        checks++; if (wbError !== 1'b1) begin failures++; $display("FAIL wberr_set: got %b want 1", wbError); end
        tick(); tick(); tick();
        checks++; if (wbError !== 1'b1) begin failures++; $display("FAIL wberr_sticky: got %b want 1", wbError); end
    endtask

    task automatic test_deadlock();
        issue_write(5'd4);
        idValid = 1; useRs = 1; rs = 4;
        for (int i = 0; i < 63; i++) begin
            tick();
        end
        checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL deadlock_63: got %b want 0", deadlock); end
        tick();
        checks++; if (deadlock !== 1'b1) begin failures++; $display("FAIL deadlock_64: got %b want 1", deadlock); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL deadlock_still_stall: got %b want 1", stall); end
        reset = 1;
        tick();
        checks++; if (deadlock !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL deadlock_reset: got deadlock=%b stall=%b want 0 0", deadlock, stall); end
        checks++; if (wbError !== 1'b0 || stallCycles !== 16'd0) begin failures++; $display("FAIL deadlock_reset_regs: got wbError=%b stallCycles=%0d want 0 0", wbError, stallCycles); end
        reset = 0;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_issue_r5();
        test_raw_wb();
        test_r0();
        test_waw();
        test_flush();
        test_wb_error();
        test_deadlock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_hazard_scoreboard

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Scoreboard-based hazard controller for the MIPS instruction-decode stage (register file, write-address mux, sign extender).
- Tracks which architectural registers have an in-flight write pending.
- Stalls decode on RAW or WAW hazards against those registers.
- Releases the stall when writeback retires the register.
- Sits between ID and the pipeline control; drives the ID stall/issue signals and consumes writeback completions.

Parameters:
NUM_REGS, 32, number of architectural registers (register 0 hardwired zero)
ADDR_W, 5, register address width, log2(NUM_REGS)
STALL_CNT_W, 16, width of saturating stall-cycle counter
STALL_LIMIT, 64, consecutive stall cycles before the deadlock flag is raised

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
idValid  input  1  ID holds a valid decoded instruction
useRs  input  1  instruction reads rs
useRt  input  1  instruction reads rt
rs  input  ADDR_W  source register 1 (instruction32[25:21])
rt  input  ADDR_W  source register 2 (instruction32[20:16])
regWrite  input  1  instruction writes a register
writeAddress  input  ADDR_W  destination after regDst mux
wbValid  input  1  writeback retires a register write this cycle
wbAddress  input  ADDR_W  register being retired
flush  input  1  discard all in-flight writes (branch or exception)
stall  output  1  hold ID this cycle
issue  output  1  instruction leaves ID this cycle
pendingCount  output  ADDR_W+1  number of pending registers
stallCycles  output  STALL_CNT_W  saturating count of stalled cycles
wbError  output  1  sticky; writeback to a non-pending register
deadlock  output  1  sticky; stall held for STALL_LIMIT consecutive cycles

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: pending[NUM_REGS-1:0]=0, stallCycles=0, wbError=0, deadlock=0, internal run-length counter=0. Outputs derived from these are 0 while reset is asserted.
- State is the pending bit vector plus the counters. pending[0] is always 0; writes to register 0 are never tracked.
- Hazard (combinational from registered state):
  - rawRs = useRs & rs!=0 & pending[rs]
  - rawRt = useRt & rt!=0 & pending[rt]
  - waw = regWrite & writeAddress!=0 & pending[writeAddress]
- stall = idValid & (rawRs | rawRt | waw) & ~flush. Zero-cycle latency.
- issue = idValid & ~stall & ~flush.
- On issue with regWrite & writeAddress!=0: pending[writeAddress] is set at the next edge.
- On wbValid & wbAddress!=0:
  - pending[wbAddress] is cleared at the next edge.
  - If pending[wbAddress] was already 0, wbError sets and stays set until reset.
- Simultaneous set and clear of the same register: set wins. This occurs only in bypass mode or on an erroneous writeback.
- flush: all pending bits clear at the next edge. flush overrides any same-cycle issue or writeback. wbError is not raised by a writeback during flush.
- pendingCount is the registered popcount of pending, updated one cycle after the pending change.
- stallCycles increments each cycle stall=1 and saturates at all-ones.
- Run-length counter increments while stall=1 and resets to 0 when stall=0. When it reaches STALL_LIMIT, deadlock sets and stays set.
- Reset asserted mid-stall: stall drops the next cycle, because all pending bits clear.

Optional Feature:
Macro HZ_WB_BYPASS_EN.
- Defined: the register file writes before it reads. A same-cycle wbValid to register X masks RAW hazards on X that cycle, so the instruction issues with no bubble. It also masks a WAW on X; the new set wins and X stays pending.
- Undefined: the hazard uses registered pending only. The stall releases the cycle after writeback, which adds one bubble.

Decomposition:
- Shared package id_pkg:
  - REG_ADDR_W=5, NUM_ARCH_REGS=32
  - typedef reg_addr_t
  - ZERO_REG=0 constant
- One natural sub-module: popcount_reg. A registered popcount over the NUM_REGS-bit vector feeding pendingCount; reusable by other scoreboards.

Test Plan:
- Reset, then issue write to r5 (regWrite=1, writeAddress=5) -> pending[5]=1 next cycle; pendingCount=1 one cycle later.
- With r5 pending, ID presents useRs=1, rs=5 -> stall=1, issue=0 each cycle. wbValid, wbAddress=5 -> stall=0 the next cycle (bypass off) or the same cycle (HZ_WB_BYPASS_EN); stallCycles matches.
- Issue write to r0, then read r0 -> pending stays 0, stall never asserts.
- Pending r3 and r7; flush=1 with a same-cycle idValid write to r9 -> issue=0; all pending 0 next cycle; r9 not pending.
- wbValid, wbAddress=12 with r12 not pending -> wbError=1 next cycle and stays 1 until reset.
- Hold a RAW on r4 with no writeback for 64 cycles -> deadlock=1 on the 64th consecutive stall. Assert reset -> deadlock=0, stall=0 next cycle.
